tms1x00_core: RTL and testbench

- TMS1100-style 4-bit microcontroller core: fetches 8-bit opcodes from an external synchronous ROM (2 KiB), holds 128x4 data RAM internally, reads the K inputs, and drives the O and R output latches.
- Sits inside the chip wrapper, which supplies the ROM port and a bus-controlled halt/single-step override.

---
 rtl/tms1x00_core.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_tms1x00_core.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tms1x00_core.sv
// TMS1100-style 4-bit microcontroller core. Each instruction takes a FETCH
// cycle (ROM address out) and an EXEC cycle (opcode in, all state commits).
// Ports:
//   clk, reset    : core clock, asynchronous active-high reset
//   chip_sel_i    : run enable, sampled at the instruction boundary
//   K_in          : 4 K input lines
//   O_out, R_out  : O latch (8) and R latches (16)
//   rom_addr      : {chapter, page, pc} to a registered 2048x8 ROM
//   rom_value     : ROM data, valid one clock after rom_addr
//   wb_override   : debug halt, the core advances only on wb_step edges
//   wb_step       : single-step request (level; each 0->1 edge runs one op)
// Optional: define TMS1X00_WB_STEP_EN to enable halt/single-step. Without
// it, wb_override/wb_step are ignored and the core is gated by chip_sel_i.
module tms1x00_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        chip_sel_i,
    input  logic [3:0]  K_in,
    output logic [7:0]  O_out,
    output logic [15:0] R_out,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_value,
    input  logic        wb_override,
    input  logic        wb_step
);

    typedef enum logic {FETCH, EXEC} state_t;

    state_t     state;
    logic [5:0] pc, sr;
    logic [3:0] pa, pb;
    logic       ca, cb, cl;
    logic [3:0] a, y;
    logic [2:0] x;
    logic       s, sl;
    logic [3:0] ram [0:127];

    logic       go;
    logic       commit;

    assign commit   = (state == EXEC);
    assign rom_addr = {ca, pa, pc};

`ifdef TMS1X00_WB_STEP_EN
    logic step_q;
    logic step_pend;

    // A pending step survives until the EXEC it released has committed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q    <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_q    <= wb_step;
            step_pend <= (wb_step & ~step_q) | (step_pend & ~commit);
        end
    end

    assign go = chip_sel_i & (~wb_override | step_pend);
`else
    logic unused_wb;
    assign unused_wb = wb_override ^ wb_step;
    assign go        = chip_sel_i;
`endif

    // Decoded fields; immediates are stored bit-reversed in the opcode.
    logic [7:0] op;
    logic [3:0] m, imm;
    logic [1:0] bidx;
    logic [4:0] sum_am, sum_ai;
    logic [5:0] pc_inc;

    assign op     = rom_value;
    assign m      = ram[{x, y}];
    assign imm    = {op[0], op[1], op[2], op[3]};
    assign bidx   = {op[0], op[1]};
    assign sum_am = {1'b0, a} + {1'b0, m};
    assign sum_ai = {1'b0, a} + {1'b0, imm} + 5'd1;

    // 6-bit LFSR program counter with the two fixed-up states.
    always_comb begin
        pc_inc = {pc[4:0], ~(pc[5] ^ pc[4])};
        if (pc == 6'h1F)
            pc_inc = 6'h3F;
        else if (pc == 6'h3F)
            pc_inc = 6'h3E;
    end

    logic [3:0]  n_a, n_y, n_pa, n_pb, ram_wd;
    logic [2:0]  n_x;
    logic [5:0]  n_pc, n_sr;
    logic        n_st, n_ca, n_cb, n_cl, ram_we;
    logic [7:0]  n_o;
    logic [15:0] n_r;

    always_comb begin
        n_a    = a;
        n_x    = x;
        n_y    = y;
        n_st   = 1'b1;
        n_pc   = pc_inc;
        n_pa   = pa;
        n_pb   = pb;
        n_ca   = ca;
        n_cb   = cb;
        n_cl   = cl;
        n_sr   = sr;
        n_o    = O_out;
        n_r    = R_out;
        ram_we = 1'b0;
        ram_wd = a;

        unique case (1'b1)
            op[7]: begin
                // BR / CALL, taken on the previous status
                if (s) begin
                    n_pc = op[5:0];
                    n_pa = pb;
                    n_ca = cb;
                    if (op[6] && !cl) begin
                        n_sr = pc_inc;
                        n_pb = pa;
                        n_cl = 1'b1;
                    end
                end
            end
            op[7:4] == 4'h7: begin
                if (op[3:0] == 4'hF) begin
                    n_a = 4'h0;
                end else begin
                    n_a  = sum_ai[3:0];
                    n_st = sum_ai[4];
                end
            end
            op[7:4] == 4'h6: begin
                ram_we = 1'b1;
                ram_wd = imm;
                n_y    = y + 4'd1;
            end
            op[7:4] == 4'h5: n_st = (y != imm);
            op[7:4] == 4'h4: n_y  = imm;
            op[7:6] == 2'b00: begin
                unique casez (op[5:0])
                    6'h00: n_st = (m != a);
                    6'h01: n_st = (a <= m);
                    6'h02: n_st = (y != a);
                    6'h03: begin
                        ram_we = 1'b1;
                        n_a    = m;
                    end
                    6'h04: begin
                        n_y  = y - 4'd1;
                        n_st = (y != 4'h0);
                    end
                    6'h05: begin
                        n_y  = y + 4'd1;
                        n_st = (y == 4'hF);
                    end
                    6'h06: begin
                        n_a  = sum_am[3:0];
                        n_st = sum_am[4];
                    end
                    6'h07: begin
                        n_a  = m - 4'd1;
                        n_st = (m != 4'h0);
                    end
                    6'h08: n_a  = K_in;
                    6'h09: n_x  = x ^ 3'b100;
                    6'h0A: n_o  = {3'b000, sl, a};
                    6'h0B: n_cb = ~cb;
                    6'h0C: n_r[y] = 1'b0;
                    6'h0D: n_r[y] = 1'b1;
                    6'h0E: n_st = (K_in != 4'h0);
                    6'h0F: begin
                        n_pa = pb;
                        n_ca = cb;
                        if (cl) begin
                            n_pc = sr;
                            n_cl = 1'b0;
                        end
                    end
                    6'b01????: n_pb = imm;
                    6'h20: n_y = a;
                    6'h21: n_a = m;
                    6'h22: n_y = m;
                    6'h23: n_a = y;
                    6'h24: begin
                        ram_we = 1'b1;
                        n_y    = y - 4'd1;
                        n_st   = (y != 4'h0);
                    end
                    6'h25: begin
                        ram_we = 1'b1;
                        n_y    = y + 4'd1;
                        n_st   = (y == 4'hF);
                    end
                    6'h26: begin
                        ram_we = 1'b1;
                        n_a    = 4'h0;
                    end
                    6'h27: ram_we = 1'b1;
                    6'b101???: n_x = {op[0], op[1], op[2]};
                    6'b1100??: begin
                        ram_we       = 1'b1;
                        ram_wd       = m;
                        ram_wd[bidx] = 1'b1;
                    end
                    6'b1101??: begin
                        ram_we       = 1'b1;
                        ram_wd       = m;
                        ram_wd[bidx] = 1'b0;
                    end
                    6'b1110??: n_st = m[bidx];
                    6'h3C: begin
                        n_a  = m - a;
                        n_st = (m >= a);
                    end
                    6'h3D: begin
                        n_a  = 4'h0 - a;
                        n_st = (a == 4'h0);
                    end
                    6'h3E: begin
                        n_a  = m + 4'd1;
                        n_st = (m == 4'hF);
                    end
                    6'h3F: n_st = (m != 4'h0);
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc    <= 6'h00;
            sr    <= 6'h00;
            pa    <= 4'hF;
            pb    <= 4'hF;
            ca    <= 1'b0;
            cb    <= 1'b0;
            cl    <= 1'b0;
            a     <= 4'h0;
            x     <= 3'h0;
            y     <= 4'h0;
            s     <= 1'b1;
            sl    <= 1'b0;
            O_out <= 8'h00;
            R_out <= 16'h0000;
        end else begin
            unique case (state)
                FETCH: begin
                    if (go)
                        state <= EXEC;
                end
                EXEC: begin
                    state <= FETCH;
                    pc    <= n_pc;
                    sr    <= n_sr;
                    pa    <= n_pa;
                    pb    <= n_pb;
                    ca    <= n_ca;
                    cb    <= n_cb;
                    cl    <= n_cl;
                    a     <= n_a;
                    x     <= n_x;
                    y     <= n_y;
                    s     <= n_st;
                    sl    <= n_st;
                    O_out <= n_o;
                    R_out <= n_r;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 128; i++)
                ram[i] <= 4'h0;
        end else if (commit && ram_we) begin
            ram[{x, y}] <= ram_wd;
        end
    end

endmodule

// File: tb/tb_tms1x00_core.sv
// Scoreboard bench for tms1x00_core: directed ROM programs push the
// expected post-instruction {rom_addr, O_out, R_out}; a monitor checks them.
module tb_tms1x00_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chip_sel_i = 1'b0;
    logic [3:0]  K_in = 4'h0;
    logic [7:0]  O_out;
    logic [15:0] R_out;
    logic [10:0] rom_addr;
    logic [7:0]  rom_value = 8'h00;
    logic        wb_override = 1'b0;
    logic        wb_step = 1'b0;

    tms1x00_core dut (
        .clk         (clk),
        .reset       (reset),
        .chip_sel_i  (chip_sel_i),
        .K_in        (K_in),
        .O_out       (O_out),
        .R_out       (R_out),
        .rom_addr    (rom_addr),
        .rom_value   (rom_value),
        .wb_override (wb_override),
        .wb_step     (wb_step)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:2047];
    always @(posedge clk) rom_value <= rom[rom_addr];

    typedef struct {
        logic [10:0] a;
        logic [7:0]  o;
        logic [15:0] r;
    } exp_t;

    exp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    string scen = "none";

    task automatic chk(input string nm, input logic [34:0] act,
                       input logic [34:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s/%s: got addr=%h O=%h R=%h, expected addr=%h O=%h R=%h",
                     scen, nm, act[34:24], act[23:16], act[15:0],
                     req[34:24], req[23:16], req[15:0]);
        end
    endtask

    task automatic push(input logic [10:0] a, input logic [7:0] o,
                        input logic [15:0] r);
        exp_t e;
        e.a = a;
        e.o = o;
        e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic fill();
        for (int i = 0; i < 2048; i++)
            rom[i] = 8'h7F;
    endtask

    task automatic start(input logic cs);
        reset      = 1'b1;
        chip_sel_i = cs;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset", {rom_addr, O_out, R_out}, {11'h3C0, 8'h00, 16'h0000});
    endtask

    // Wait for the scoreboard to empty, then stall at the boundary.
    task automatic drain(input logic drop);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s/drain_timeout: %0d pending, expected 0",
                     scen, exp_q.size());
            exp_q.delete();
        end
        if (drop)
            chip_sel_i = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Monitor: an EXEC seen at the negedge commits on the next posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && dut.state == 1'b1) begin
                @(posedge clk);
                #1;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL %s/unexpected_instr: got addr=%h, expected no instruction",
                             scen, rom_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", {rom_addr, O_out, R_out}, {e.a, e.o, e.r});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [10:0] seq [10] = '{11'h3C1, 11'h3C3, 11'h3C7, 11'h3CF, 11'h3DF,
                              11'h3FF, 11'h3FE, 11'h3FD, 11'h3FB, 11'h3F7};

    initial begin
        scen = "cla_seq";
        fill();
        for (int i = 0; i < 8; i++)
            push(seq[i], 8'h00, 16'h0000);
        start(1'b1);
        drain(1'b1);

        scen = "br";
        fill();
        rom[11'h3C0] = 8'h85;
        push(11'h3C5, 8'h00, 16'h0000);
        push(11'h3CB, 8'h00, 16'h0000);
        start(1'b1);
        drain(1'b1);

        scen = "setr_rstr";
        fill();
        rom[11'h3C0] = 8'h4A;
        rom[11'h3C1] = 8'h0D;
        rom[11'h3C3] = 8'h0C;
        push(11'h3C1, 8'h00, 16'h0000);
        push(11'h3C3, 8'h00, 16'h0020);
        push(11'h3C7, 8'h00, 16'h0000);
        start(1'b1);
        drain(1'b1);

        scen = "tka_tdo";
        fill();
        K_in = 4'h9;
        rom[11'h3C0] = 8'h08;
        rom[11'h3C1] = 8'h0A;
        push(11'h3C1, 8'h00, 16'h0000);
        push(11'h3C3, 8'h19, 16'h0000);
        start(1'b1);
        drain(1'b1);

        scen = "ac1ac_nocarry";
        fill();
        rom[11'h3C0] = 8'h7F;
        rom[11'h3C1] = 8'h70;
        rom[11'h3C3] = 8'h0A;
        push(11'h3C1, 8'h00, 16'h0000);
        push(11'h3C3, 8'h00, 16'h0000);
        push(11'h3C7, 8'h01, 16'h0000);
        start(1'b1);
        drain(1'b1);

        scen = "ac1ac_carry";
        fill();
        K_in = 4'hF;
        rom[11'h3C0] = 8'h08;
        rom[11'h3C1] = 8'h70;
        rom[11'h3C3] = 8'h0A;
        push(11'h3C1, 8'h00, 16'h0000);
        push(11'h3C3, 8'h00, 16'h0000);
        push(11'h3C7, 8'h10, 16'h0000);
        start(1'b1);
        drain(1'b1);

        scen = "call_retn_ldp";
        fill();
        rom[11'h3C0] = 8'hC9;
        rom[11'h3C9] = 8'h0F;
        rom[11'h3C1] = 8'h18;
        rom[11'h3C3] = 8'h82;
        push(11'h3C9, 8'h00, 16'h0000);
        push(11'h3C1, 8'h00, 16'h0000);
        push(11'h3C3, 8'h00, 16'h0000);
        push(11'h042, 8'h00, 16'h0000);
        start(1'b1);
        drain(1'b1);

        scen = "br_untaken";
        fill();
        rom[11'h3C0] = 8'h40;
        rom[11'h3C1] = 8'h50;
        rom[11'h3C3] = 8'h85;
        push(11'h3C1, 8'h00, 16'h0000);
        push(11'h3C3, 8'h00, 16'h0000);
        push(11'h3C7, 8'h00, 16'h0000);
        start(1'b1);
        drain(1'b1);

        scen = "ram_path";
        fill();
        rom[11'h3C0] = 8'h44;
        rom[11'h3C1] = 8'h6C;
        rom[11'h3C3] = 8'h04;
        rom[11'h3C7] = 8'h21;
        rom[11'h3CF] = 8'h3E;
        rom[11'h3DF] = 8'h0A;
        for (int i = 0; i < 5; i++)
            push(seq[i], 8'h00, 16'h0000);
        push(11'h3FF, 8'h04, 16'h0000);
        start(1'b1);
        drain(1'b1);

        scen = "chip_sel_stall";
        fill();
        start(1'b0);
        repeat (10) @(negedge clk);
        chk("idle", {rom_addr, O_out, R_out}, {11'h3C0, 8'h00, 16'h0000});
        push(11'h3C1, 8'h00, 16'h0000);
        push(11'h3C3, 8'h00, 16'h0000);
        chip_sel_i = 1'b1;
        drain(1'b1);
        repeat (10) @(negedge clk);
        chk("stalled", {rom_addr, O_out, R_out}, {11'h3C3, 8'h00, 16'h0000});

`ifdef TMS1X00_WB_STEP_EN
        scen = "wb_step";
        fill();
        wb_override = 1'b1;
        start(1'b1);
        repeat (20) @(negedge clk);
        chk("halted", {rom_addr, O_out, R_out}, {11'h3C0, 8'h00, 16'h0000});
        push(11'h3C1, 8'h00, 16'h0000);
        wb_step = 1'b1;
        drain(1'b0);
        repeat (10) @(negedge clk);
        chk("one_step", {rom_addr, O_out, R_out}, {11'h3C1, 8'h00, 16'h0000});
        wb_step = 1'b0;
        repeat (2) @(negedge clk);
        chip_sel_i = 1'b0;
        wb_step    = 1'b1;
        repeat (10) @(negedge clk);
        chk("cs_low", {rom_addr, O_out, R_out}, {11'h3C1, 8'h00, 16'h0000});
        wb_step     = 1'b0;
        wb_override = 1'b0;
`else
        scen = "wb_ignored";
        fill();
        wb_override = 1'b1;
        for (int i = 0; i < 10; i++)
            push(seq[i], 8'h00, 16'h0000);
        start(1'b1);
        drain(1'b1);
        wb_override = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
